noc_vc_switch_allocator: RTL and testbench

NOC_VC_SWITCH_ALLOCATOR -- requirements
Module: noc_vc_switch_allocator

---
 rtl/noc_vc_switch_allocator_pkg.sv | 18 +
 rtl/noc_vc_switch_allocator_if.sv | 32 +++
 rtl/noc_vc_switch_allocator_rr_arbiter.sv | 31 +++
 rtl/noc_vc_switch_allocator.sv | 175 +++++++++++++++++
 tb/tb_noc_vc_switch_allocator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_switch_allocator_pkg.sv
// ---------------------------------------------------------------------------
// Noc_parameters
//   Shared constants and types for the NoC virtual-channel switch allocator.
//   Noc_VC_Channel   : default number of requesting virtual channels
//   Noc_Credit_Depth : default downstream buffer slots (credits) per channel
//   alloc_state_t    : allocator FSM state, also exported on the debug port
// ---------------------------------------------------------------------------
package Noc_parameters;

  localparam int Noc_VC_Channel   = 4;
  localparam int Noc_Credit_Depth = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/noc_vc_switch_allocator_if.sv
// ---------------------------------------------------------------------------
// Noc_control_interface
//   Per-channel control bundle between the virtual-channel requesters and the
//   switch allocator. Every signal is one bit per channel.
//   request         : channel has a flit ready to send
//   grant           : allocator permits the channel to send (registered)
//   free            : one-cycle pulse, downstream released one buffer slot
//   start_of_packet : the offered flit is the head of a packet
//   end_of_packet   : the offered flit is the tail of a packet
//   Modport controller is the allocator's view.
// ---------------------------------------------------------------------------
interface Noc_control_interface
  import Noc_parameters::*;
#(
  parameter int Channel = Noc_VC_Channel
) ();

  logic [Channel-1:0] request;
  logic [Channel-1:0] grant;
  logic [Channel-1:0] free;
  logic [Channel-1:0] start_of_packet;
  logic [Channel-1:0] end_of_packet;

  modport controller (
    input  request,
    input  free,
    input  start_of_packet,
    input  end_of_packet,
    output grant
  );

endinterface

// File: rtl/noc_vc_switch_allocator_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
//   Combinational rotating-priority selector. Searches req starting at index
//   ptr and wrapping; the first set bit wins.
//   req     : request vector
//   ptr     : index holding highest priority this cycle
//   gnt     : one-hot winner (zero when req is zero)
//   gnt_idx : binary index of the winner (zero when req is zero)
// ---------------------------------------------------------------------------
module noc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if ((gnt == '0) && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx                  = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/noc_vc_switch_allocator.sv
// ---------------------------------------------------------------------------
// noc_vc_switch_allocator
//   Grants the output switch to one virtual channel for a whole packet, with
//   per-channel credit tracking of the downstream buffer.
//
//   Ports
//     clk        : clock, all state on the rising edge
//     rst_n      : asynchronous active-low reset
//     ctrl       : Noc_control_interface.controller (request/grant/free/
//                  start_of_packet/end_of_packet, Channel bits each)
//     sel        : index of the channel transferring a flit this cycle
//     sel_valid  : a flit transfer occurs this cycle
//     credit_err : one-cycle pulse after a free arrived on a full counter
//     state_dbg  : current FSM state (IDLE / LOCKED)
//     pkt_count  : packets completed, 32-bit wrapping (only when the macro
//                  NOC_VC_ALLOC_STATS_EN is defined)
//
//   Handshake: a flit moves on channel i exactly in a cycle where
//   request[i] and grant[i] are both high. grant is registered and is only
//   ever raised on the lock owner while it holds a credit, so the requester
//   may drop or hold request freely; a held grant with no request simply
//   moves nothing, and a request with no grant must wait.
// ---------------------------------------------------------------------------
module noc_vc_switch_allocator
  import Noc_parameters::*;
#(
  parameter int Channel = Noc_VC_Channel,
  parameter int Depth   = Noc_Credit_Depth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  Noc_control_interface.controller     ctrl,
  output logic [$clog2(Channel)-1:0]   sel,
  output logic                         sel_valid,
  output logic                         credit_err,
  output alloc_state_t                 state_dbg
`ifdef NOC_VC_ALLOC_STATS_EN
  ,
  output logic [31:0]                  pkt_count
`endif
);

  localparam int SW = $clog2(Channel);
  localparam int CW = $clog2(Depth + 1);
  localparam logic [Channel-1:0] ONE_HOT0 = Channel'(1);
  localparam logic [CW-1:0]      FULL     = CW'(Depth);

  logic [Channel-1:0]         req;
  logic [Channel-1:0]         sop;
  logic [Channel-1:0]         eop;
  logic [Channel-1:0]         free;
  logic [Channel-1:0]         xfer;
  logic [Channel-1:0]         has_credit;
  logic [Channel-1:0]         elig;
  logic [Channel-1:0]         overflow;
  logic [Channel-1:0]         arb_gnt;
  logic [Channel-1:0]         owner_gnt;
  logic [Channel-1:0]         grant_q;
  logic [Channel-1:0][CW-1:0] credit_q;
  logic [Channel-1:0][CW-1:0] credit_nxt;
  logic [SW-1:0]              owner_q;
  logic [SW-1:0]              owner_inc;
  logic [SW-1:0]              rr_q;
  logic [SW-1:0]              arb_idx;
  logic [SW-1:0]              sel_idx;
  logic                       credit_err_q;
  alloc_state_t               state_q;

  assign req        = ctrl.request;
  assign sop        = ctrl.start_of_packet;
  assign eop        = ctrl.end_of_packet;
  assign free       = ctrl.free;
  assign ctrl.grant = grant_q;

  assign xfer = req & grant_q;

  // ---- credit bookkeeping -------------------------------------------------
  // A transfer and a free in the same cycle cancel. A lone free on a full
  // counter is dropped and reported; a transfer can never hit an empty
  // counter because grant is only raised while a credit is available.
  for (genvar i = 0; i < Channel; i++) begin : g_credit
    assign has_credit[i] = (credit_q[i] != '0);
    assign overflow[i]   = free[i] & ~xfer[i] & (credit_q[i] == FULL);
    assign credit_nxt[i] = (xfer[i] & ~free[i])                ? credit_q[i] - CW'(1) :
                           (free[i] & ~xfer[i] & ~overflow[i]) ? credit_q[i] + CW'(1) :
                                                                 credit_q[i];
  end

  // ---- arbitration --------------------------------------------------------
  assign elig = req & sop & has_credit;

  noc_rr_arbiter #(
    .N  (Channel),
    .IW (SW)
  ) u_arb (
    .req     (elig),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign owner_gnt = ONE_HOT0 << owner_q;
  assign owner_inc = (owner_q == SW'(Channel - 1)) ? '0 : owner_q + SW'(1);

  // ---- transfer report ----------------------------------------------------
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < Channel; i++) begin
      if (xfer[i]) sel_idx = SW'(i);
    end
  end

  assign sel        = sel_idx;
  assign sel_valid  = |xfer;
  assign credit_err = credit_err_q;
  assign state_dbg  = state_q;

  // ---- FSM, grant and credits ---------------------------------------------
  // Grant is computed from next-cycle credit so a stalled owner resumes the
  // cycle after a free arrives, and never sends into a full downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      credit_q     <= {Channel{FULL}};
      credit_err_q <= 1'b0;
    end else begin
      credit_q     <= credit_nxt;
      credit_err_q <= |overflow;
      case (state_q)
        ST_IDLE: begin
          // No transfer can happen in IDLE (grant is low), so the winner's
          // credit is still non-zero next cycle.
          if (|elig) begin
            state_q <= ST_LOCKED;
            owner_q <= arb_idx;
            grant_q <= arb_gnt;
          end else begin
            grant_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (xfer[owner_q] & eop[owner_q]) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= owner_inc;
          end else begin
            grant_q <= (credit_nxt[owner_q] != '0) ? owner_gnt : '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef NOC_VC_ALLOC_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else if (|(xfer & eop)) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_noc_vc_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_noc_vc_switch_allocator
//   Two allocators with Channel=4: dut_a with Depth=4 driven from a vector
//   table, dut_b with Depth=2 driven by a hand-written credit-stall sequence.
//   With NOC_VC_ALLOC_STATS_EN defined the packet counter is also exercised.
// ---------------------------------------------------------------------------
module tb_noc_vc_switch_allocator;
  import Noc_parameters::*;

  localparam int CH = 4;

  // ---- clock / reset ------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  Noc_control_interface #(.Channel(CH)) ifa ();
  Noc_control_interface #(.Channel(CH)) ifb ();

  logic [1:0]   sel_a, sel_b;
  logic         sel_valid_a, sel_valid_b;
  logic         credit_err_a, credit_err_b;
  alloc_state_t state_a, state_b;
`ifdef NOC_VC_ALLOC_STATS_EN
  logic [31:0]  pkt_count_a, pkt_count_b;
`endif

  noc_vc_switch_allocator #(.Channel(CH), .Depth(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ifa),
    .sel        (sel_a),
    .sel_valid  (sel_valid_a),
    .credit_err (credit_err_a),
    .state_dbg  (state_a)
`ifdef NOC_VC_ALLOC_STATS_EN
    ,
    .pkt_count  (pkt_count_a)
`endif
  );

  noc_vc_switch_allocator #(.Channel(CH), .Depth(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ifb),
    .sel        (sel_b),
    .sel_valid  (sel_valid_b),
    .credit_err (credit_err_b),
    .state_dbg  (state_b)
`ifdef NOC_VC_ALLOC_STATS_EN
    ,
    .pkt_count  (pkt_count_b)
`endif
  );

  // ---- checking -----------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Scoreboard of expected sel values for every transfer on dut_b.
  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;

  always @(negedge clk) begin
    if (rst_n && sel_valid_b) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_b_unexpected got=%0d want=none", sel_b);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_b_sel", 0, 32'(sel_b), 32'(sb_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---- vector table for dut_a ---------------------------------------------
  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  sop;
    logic [3:0]  eop;
    logic [3:0]  free;
    logic [3:0]  grant;
    logic        sv;
    logic [1:0]  sel;
    logic        cerr;
    logic [11:0] cred;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] cr(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] sp,
                              input logic [3:0] ep, input logic [3:0] fr, input logic [3:0] g,
                              input logic v, input logic [1:0] s, input logic ce,
                              input logic [11:0] c);
    vec_t t;
    t.rstn = r;  t.req = rq; t.sop = sp; t.eop = ep; t.free = fr;
    t.grant = g; t.sv = v;   t.sel = s;  t.cerr = ce; t.cred = c;
    return t;
  endfunction

  // ---- drivers ------------------------------------------------------------
  task automatic zero_inputs();
    ifa.request = '0; ifa.start_of_packet = '0; ifa.end_of_packet = '0; ifa.free = '0;
    ifb.request = '0; ifb.start_of_packet = '0; ifb.end_of_packet = '0; ifb.free = '0;
  endtask

  task automatic step_b(input int k, input logic [3:0] rq, input logic [3:0] sp,
                        input logic [3:0] ep, input logic [3:0] fr, input logic [3:0] g,
                        input logic v, input alloc_state_t st, input logic [1:0] c1);
    @(posedge clk); #1;
    ifb.request = rq; ifb.start_of_packet = sp; ifb.end_of_packet = ep; ifb.free = fr;
    @(negedge clk);
    chk("b_grant",     k, 32'(ifb.grant),        32'(g));
    chk("b_sel_valid", k, 32'(sel_valid_b),      32'(v));
    chk("b_state",     k, 32'(state_b),          32'(st));
    chk("b_credit1",   k, 32'(dut_b.credit_q[1]), 32'(c1));
  endtask

`ifdef NOC_VC_ALLOC_STATS_EN
  logic [3:0] pk_oh;
`endif

  // ---- main sequence ------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_grant",  0, 32'(ifa.grant),      32'h0);
    chk("rst_a_state",  0, 32'(state_a),        32'(ST_IDLE));
    chk("rst_a_cred",   0, 32'(dut_a.credit_q), 32'(cr(4, 4, 4, 4)));
    chk("rst_a_cerr",   0, 32'(credit_err_a),   32'h0);
    chk("rst_b_grant",  0, 32'(ifb.grant),      32'h0);
    chk("rst_b_cred",   0, 32'(dut_b.credit_q), 32'h0000_00AA);

    // ch2 three-flit packet
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, cr(4, 3, 4, 4)));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 0, cr(4, 2, 4, 4)));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 1, 4, 4)));
    // reset, then ch0 vs ch3 round robin
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3, 0, cr(4, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(3, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0, cr(3, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(3, 4, 4, 2)));
    // free on a full counter, then a legal free on ch0
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 2'd0, 0, cr(3, 4, 4, 2)));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 2'd0, 1, cr(3, 4, 4, 2)));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(3, 4, 4, 3)));
    // ch1 locks; transfer+free cancel; ch2 waits; reset mid-packet
    vecs.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(3, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b0110, 4'b0110, 4'b0000, 4'b0010, 4'b0010, 1, 2'd1, 0, cr(3, 4, 4, 3)));
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, cr(3, 4, 4, 3)));
    vecs.push_back(mk(0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    // requester must restart with start_of_packet
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 0, cr(4, 4, 4, 4)));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, cr(4, 4, 3, 4)));

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      rst_n               = vecs[k].rstn;
      ifa.request         = vecs[k].req;
      ifa.start_of_packet = vecs[k].sop;
      ifa.end_of_packet   = vecs[k].eop;
      ifa.free            = vecs[k].free;
      @(negedge clk);
      chk("a_grant",      k, 32'(ifa.grant),      32'(vecs[k].grant));
      chk("a_sel_valid",  k, 32'(sel_valid_a),    32'(vecs[k].sv));
      if (vecs[k].sv) chk("a_sel", k, 32'(sel_a), 32'(vecs[k].sel));
      chk("a_credit_err", k, 32'(credit_err_a),   32'(vecs[k].cerr));
      chk("a_credits",    k, 32'(dut_a.credit_q), 32'(vecs[k].cred));
    end
    @(posedge clk); #1;
    zero_inputs();

    // Depth=2: 4-flit packet on ch1 stalls on credits, keeps its lock,
    // keeps grant while its request is low, then ch0 follows.
    exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    step_b(0,  4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, ST_IDLE,   2'd2);
    step_b(1,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, ST_LOCKED, 2'd2);
    step_b(2,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, ST_LOCKED, 2'd1);
    step_b(3,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, ST_LOCKED, 2'd0);
    step_b(4,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, ST_LOCKED, 2'd0);
    step_b(5,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, ST_LOCKED, 2'd1);
    step_b(6,  4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, ST_LOCKED, 2'd0);
    step_b(7,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 0, ST_LOCKED, 2'd1);
    step_b(8,  4'b0011, 4'b0001, 4'b0010, 4'b0000, 4'b0010, 1, ST_LOCKED, 2'd1);
    step_b(9,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, ST_IDLE,   2'd0);
    step_b(10, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, ST_LOCKED, 2'd0);
    step_b(11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, ST_IDLE,   2'd0);
    chk("sb_b_left", 0, 32'(exp_q.size()), 32'h0);

`ifdef NOC_VC_ALLOC_STATS_EN
    @(posedge clk); #1;
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    chk("pkt_count_rst", 0, pkt_count_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pk_oh = 4'b0001 << (p % 4);
      @(posedge clk); #1;
      ifa.request = pk_oh; ifa.start_of_packet = pk_oh; ifa.end_of_packet = pk_oh;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pkt_grant", p, 32'(ifa.grant), 32'(pk_oh));
      @(posedge clk); #1;
      zero_inputs();
    end
    @(negedge clk);
    chk("pkt_count", 0, pkt_count_a, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
